// File: rtl/gnn_mlp_engine_pkg.sv
// Shared types, width rules and flat-array index helpers for the per-node MLP engine.
package gnn_mlp_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int hid_w(input int data_w, input int n_in);
    return 2 * data_w + $clog2(n_in);
  endfunction

  function automatic int acc_w_min(input int data_w, input int n_in, input int n_hid);
    return 3 * data_w + $clog2(n_in) + $clog2(n_hid);
  endfunction

  function automatic int x_idx(input int n, input int i, input int n_in);
    return n * n_in + i;
  endfunction

  function automatic int w1_idx(input int i, input int h, input int n_hid);
    return i * n_hid + h;
  endfunction

  function automatic int w2_idx(input int h, input int o, input int n_out);
    return h * n_out + o;
  endfunction

  function automatic int y_idx(input int n, input int o, input int n_out);
    return n * n_out + o;
  endfunction

endpackage

// File: rtl/gnn_mlp_engine_if.sv
// Job-in / result-out bundle of the MLP engine; master is the loader/consumer side.
interface gnn_mlp_engine_if #(
  parameter int N_NODES = 4,
  parameter int N_IN    = 4,
  parameter int N_HID   = 4,
  parameter int N_OUT   = 2,
  parameter int DATA_W  = 5,
  parameter int ACC_W   = 21
);
  // Both sides are valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; valid never depends on ready, and the producer holds
  // its payload while valid is high and ready is low.
  logic                              in_valid;
  logic                              in_ready;
  logic [N_NODES*N_IN*DATA_W-1:0]    x_flat;
  logic [N_IN*N_HID*DATA_W-1:0]      w1_flat;
  logic [N_HID*N_OUT*DATA_W-1:0]     w2_flat;
  logic                              relu_en;
  logic                              out_valid;
  logic                              out_ready;
  logic [N_NODES*N_OUT*ACC_W-1:0]    y_flat;
  logic                              busy;

  modport master (
    output in_valid, x_flat, w1_flat, w2_flat, relu_en, out_ready,
    input  in_ready, out_valid, y_flat, busy
  );

  modport slave (
    input  in_valid, x_flat, w1_flat, w2_flat, relu_en, out_ready,
    output in_ready, out_valid, y_flat, busy
  );

endinterface

// File: rtl/gnn_mlp_engine_mac.sv
// Signed multiply-accumulate; clr_first starts a new sum with the current product.
module gnn_mlp_engine_mac #(
  parameter int A_W   = 12,
  parameter int B_W   = 5,
  parameter int ACC_W = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr_first,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [A_W+B_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_q;

  assign prod     = a * b;
  assign prod_ext = prod;
  // Combinational running total so the owner can store a finished sum on its last term.
  assign sum      = (clr_first ? '0 : acc_q) + prod_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/gnn_mlp_engine.sv
// Time-multiplexed two-layer per-node MLP: one shared MAC walks L1 then L2 for each node.
module gnn_mlp_engine
  import gnn_mlp_engine_pkg::*;
#(
  parameter int N_NODES = 4,
  parameter int N_IN    = 4,
  parameter int N_HID   = 4,
  parameter int N_OUT   = 2,
  parameter int DATA_W  = 5,
  parameter int ACC_W   = 21
) (
  input  logic              clk,
  input  logic              rst,
  gnn_mlp_engine_if.slave   bus,
  output state_e            state_dbg
);

  localparam int H_W = hid_w(DATA_W, N_IN);
  localparam int NW  = clog2_min1(N_NODES);
  localparam int IW  = clog2_min1(N_IN);
  localparam int HW  = clog2_min1(N_HID);
  localparam int OW  = clog2_min1(N_OUT);

  localparam logic [NW-1:0] N_LAST = NW'(N_NODES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [HW-1:0] H_LAST = HW'(N_HID - 1);
  localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);

  generate
    if (ACC_W < acc_w_min(DATA_W, N_IN, N_HID)) begin : g_acc_w_check
      $error("gnn_mlp_engine: ACC_W too small for exact accumulation");
    end
  endgenerate

  state_e                           state;
  logic                             out_valid_q;
  logic                             busy_q;
  logic                             relu_q;
  logic [N_NODES*N_IN*DATA_W-1:0]   x_q;
  logic [N_IN*N_HID*DATA_W-1:0]     w1_q;
  logic [N_HID*N_OUT*DATA_W-1:0]    w2_q;
  logic [N_NODES*N_OUT*ACC_W-1:0]   y_q;
  logic signed [H_W-1:0]            hid [N_HID];
  logic [NW-1:0]                    cnt_n;
  logic [IW-1:0]                    cnt_i;
  logic [HW-1:0]                    cnt_h;
  logic [OW-1:0]                    cnt_o;

  logic signed [DATA_W-1:0] x_el;
  logic signed [DATA_W-1:0] w1_el;
  logic signed [DATA_W-1:0] w2_el;
  logic signed [H_W-1:0]    x_ext;
  logic                     mac_en;
  logic                     mac_clr;
  logic signed [H_W-1:0]    mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic signed [ACC_W-1:0]  mac_sum;

  assign x_el  = x_q[x_idx(int'(cnt_n), int'(cnt_i), N_IN) * DATA_W +: DATA_W];
  assign w1_el = w1_q[w1_idx(int'(cnt_i), int'(cnt_h), N_HID) * DATA_W +: DATA_W];
  assign w2_el = w2_q[w2_idx(int'(cnt_h), int'(cnt_o), N_OUT) * DATA_W +: DATA_W];
  assign x_ext = x_el;

  // Operand muxes: features feed the MAC in L1, stored hidden values in L2.
  always_comb begin
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    mac_a   = '0;
    mac_b   = '0;
    case (state)
      L1: begin
        mac_en  = 1'b1;
        mac_clr = (cnt_i == '0);
        mac_a   = x_ext;
        mac_b   = w1_el;
      end
      L2: begin
        mac_en  = 1'b1;
        mac_clr = (cnt_h == '0);
        mac_a   = hid[cnt_h];
        mac_b   = w2_el;
      end
      default: ;
    endcase
  end

  gnn_mlp_engine_mac #(
    .A_W   (H_W),
    .B_W   (DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .en        (mac_en),
    .clr_first (mac_clr),
    .a         (mac_a),
    .b         (mac_b),
    .sum       (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      relu_q      <= 1'b0;
      x_q         <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      y_q         <= '0;
      cnt_n       <= '0;
      cnt_i       <= '0;
      cnt_h       <= '0;
      cnt_o       <= '0;
      for (int k = 0; k < N_HID; k++) hid[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_q    <= bus.x_flat;
            w1_q   <= bus.w1_flat;
            w2_q   <= bus.w2_flat;
            relu_q <= bus.relu_en;
            cnt_n  <= '0;
            cnt_i  <= '0;
            cnt_h  <= '0;
            cnt_o  <= '0;
            busy_q <= 1'b1;
            state  <= L1;
          end
        end
        L1: begin
          if (cnt_i == I_LAST) begin
            hid[cnt_h] <= (relu_q && mac_sum[ACC_W-1]) ? '0 : mac_sum[H_W-1:0];
            cnt_i      <= '0;
            if (cnt_h == H_LAST) begin
              cnt_h <= '0;
              cnt_o <= '0;
              state <= L2;
            end else begin
              cnt_h <= cnt_h + 1'b1;
            end
          end else begin
            cnt_i <= cnt_i + 1'b1;
          end
        end
        L2: begin
          if (cnt_h == H_LAST) begin
            y_q[y_idx(int'(cnt_n), int'(cnt_o), N_OUT) * ACC_W +: ACC_W] <= mac_sum;
            cnt_h <= '0;
            if (cnt_o == O_LAST) begin
              cnt_o <= '0;
              if (cnt_n == N_LAST) begin
                cnt_n       <= '0;
                busy_q      <= 1'b0;
                out_valid_q <= 1'b1;
                state       <= DONE;
              end else begin
                cnt_n <= cnt_n + 1'b1;
                state <= L1;
              end
            end else begin
              cnt_o <= cnt_o + 1'b1;
            end
          end else begin
            cnt_h <= cnt_h + 1'b1;
          end
        end
        DONE: begin
          // Always return through IDLE so the loader sees one idle cycle between jobs.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.y_flat    = y_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_gnn_mlp_engine.sv
// Directed and model-checked jobs for gnn_mlp_engine: reset, extremes, ReLU, backpressure, random.
module tb_gnn_mlp_engine;
  import gnn_mlp_engine_pkg::*;

  localparam int N_NODES = 4;
  localparam int N_IN    = 4;
  localparam int N_HID   = 4;
  localparam int N_OUT   = 2;
  localparam int DATA_W  = 5;
  localparam int ACC_W   = 21;
  localparam int XW      = N_NODES * N_IN * DATA_W;
  localparam int W1W     = N_IN * N_HID * DATA_W;
  localparam int W2W     = N_HID * N_OUT * DATA_W;
  localparam int YW      = N_NODES * N_OUT * ACC_W;
  localparam int LAT     = 96;

  logic   clk = 1'b0;
  logic   rst;
  state_e state_dbg;

  gnn_mlp_engine_if bus ();

  gnn_mlp_engine dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [YW-1:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] fill_d(input int v, input int cnt);
    logic [127:0] r;
    logic [31:0]  t;
    r = '0;
    t = v;
    for (int k = 0; k < cnt; k++) r[k*DATA_W +: DATA_W] = t[DATA_W-1:0];
    return r;
  endfunction

  function automatic logic [YW-1:0] fill_y(input int v);
    logic [YW-1:0] r;
    logic [31:0]   t;
    t = v;
    for (int k = 0; k < N_NODES * N_OUT; k++) r[k*ACC_W +: ACC_W] = t[ACC_W-1:0];
    return r;
  endfunction

  function automatic int el(input logic [127:0] v, input int k);
    logic signed [DATA_W-1:0] e;
    e = v[k*DATA_W +: DATA_W];
    return int'(e);
  endfunction

  function automatic logic [YW-1:0] ref_y(input logic [XW-1:0] x, input logic [W1W-1:0] w1,
                                          input logic [W2W-1:0] w2, input logic relu);
    logic [YW-1:0] r;
    logic [31:0]   t;
    int            hid [N_HID];
    int            s;
    r = '0;
    for (int n = 0; n < N_NODES; n++) begin
      for (int h = 0; h < N_HID; h++) begin
        s = 0;
        for (int i = 0; i < N_IN; i++) s += el(128'(x), n*N_IN + i) * el(128'(w1), i*N_HID + h);
        hid[h] = (relu && s < 0) ? 0 : s;
      end
      for (int o = 0; o < N_OUT; o++) begin
        s = 0;
        for (int h = 0; h < N_HID; h++) s += hid[h] * el(128'(w2), h*N_OUT + o);
        t = s;
        r[(n*N_OUT + o)*ACC_W +: ACC_W] = t[ACC_W-1:0];
      end
    end
    return r;
  endfunction

  // Offers a job, scrambles the inputs right after acceptance, and counts edges to out_valid.
  task automatic run_job(input logic [XW-1:0] x, input logic [W1W-1:0] w1,
                         input logic [W2W-1:0] w2, input logic relu,
                         output int lat, output logic busy_seen);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    bus.x_flat   = x;
    bus.w1_flat  = w1;
    bus.w2_flat  = w2;
    bus.relu_en  = relu;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.x_flat   = XW'({$urandom(), $urandom(), $urandom()});
    bus.w1_flat  = W1W'({$urandom(), $urandom(), $urandom()});
    bus.w2_flat  = W2W'({$urandom(), $urandom()});
    bus.relu_en  = ~relu;
    busy_seen    = (bus.busy === 1'b1) && (state_dbg === L1);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic release_job();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.relu_en   = 1'b0;
    bus.x_flat    = '0;
    bus.w1_flat   = '0;
    bus.w2_flat   = '0;
    repeat (3) step();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL reset_ctrl: out_valid=%b busy=%b state=%0d, required 0 0 0",
               bus.out_valid, bus.busy, state_dbg);
    end
    n_vec++;
    if (bus.y_flat !== '0) begin
      n_err++;
      $display("FAIL reset_y: y_flat=%h required 0", bus.y_flat);
    end
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready_hi: in_ready=%b required 0", bus.in_ready);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready_lo: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_max();
    int   lat;
    logic bs;
    run_job(XW'(fill_d(15, 16)), W1W'(fill_d(15, 16)), W2W'(fill_d(15, 8)), 1'b1, lat, bs);
    n_vec++;
    if (!bs) begin
      n_err++;
      $display("FAIL max_busy: busy/L1 not seen after accept");
    end
    n_vec++;
    if (lat !== LAT) begin
      n_err++;
      $display("FAIL max_latency: %0d edges, required %0d", lat, LAT);
    end
    n_vec++;
    if (bus.y_flat !== fill_y(54000)) begin
      n_err++;
      $display("FAIL max_y: y_flat=%h required %h", bus.y_flat, fill_y(54000));
    end
    n_vec++;
    if (bus.busy !== 1'b0 || state_dbg !== DONE) begin
      n_err++;
      $display("FAIL max_done: busy=%b state=%0d, required 0 %0d", bus.busy, state_dbg, DONE);
    end
    release_job();
    n_vec++;
    if (bus.out_valid !== 1'b0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL max_release: out_valid=%b state=%0d, required 0 0", bus.out_valid, state_dbg);
    end
  endtask

  task automatic test_min();
    int   lat;
    logic bs;
    for (int r = 0; r < 2; r++) begin
      run_job(XW'(fill_d(-16, 16)), W1W'(fill_d(-16, 16)), W2W'(fill_d(-16, 8)), r[0], lat, bs);
      n_vec++;
      if (lat !== LAT) begin
        n_err++;
        $display("FAIL min_latency relu=%0d: %0d edges, required %0d", r, lat, LAT);
      end
      n_vec++;
      if (bus.y_flat !== fill_y(-65536)) begin
        n_err++;
        $display("FAIL min_y relu=%0d: y_flat=%h required %h", r, bus.y_flat, fill_y(-65536));
      end
      release_job();
    end
  endtask

  task automatic test_relu();
    int   lat;
    logic bs;
    int   exp_v;
    for (int r = 1; r >= 0; r--) begin
      exp_v = (r == 1) ? 0 : -16;
      run_job(XW'(fill_d(1, 16)), W1W'(fill_d(-1, 16)), W2W'(fill_d(1, 8)), r[0], lat, bs);
      n_vec++;
      if (lat !== LAT || bus.y_flat !== fill_y(exp_v)) begin
        n_err++;
        $display("FAIL relu_y relu=%0d: lat=%0d y_flat=%h, required %0d %h",
                 r, lat, bus.y_flat, LAT, fill_y(exp_v));
      end
      release_job();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    logic bs;
    run_job(XW'(fill_d(2, 16)), W1W'(fill_d(3, 16)), W2W'(fill_d(-1, 8)), 1'b0, lat, bs);
    n_vec++;
    if (lat !== LAT || bus.y_flat !== fill_y(-96)) begin
      n_err++;
      $display("FAIL bp_first: lat=%0d y_flat=%h, required %0d %h", lat, bus.y_flat, LAT, fill_y(-96));
    end
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      bus.x_flat   = XW'(fill_d(7, 16));
      step();
      n_vec++;
      if (bus.y_flat !== fill_y(-96) || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          state_dbg !== DONE) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d: y=%h in_ready=%b out_valid=%b state=%0d",
                 k, bus.y_flat, bus.in_ready, bus.out_valid, state_dbg);
      end
    end
    bus.in_valid = 1'b0;
    release_job();
    n_vec++;
    if (state_dbg !== IDLE || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.y_flat !== fill_y(-96)) begin
      n_err++;
      $display("FAIL bp_release: state=%0d out_valid=%b in_ready=%b y=%h",
               state_dbg, bus.out_valid, bus.in_ready, bus.y_flat);
    end
    run_job(XW'(fill_d(1, 16)), W1W'(fill_d(-1, 16)), W2W'(fill_d(1, 8)), 1'b0, lat, bs);
    n_vec++;
    if (!bs || lat !== LAT || bus.y_flat !== fill_y(-16)) begin
      n_err++;
      $display("FAIL bp_next_job: busy_seen=%b lat=%0d y=%h, required 1 %0d %h",
               bs, lat, bus.y_flat, LAT, fill_y(-16));
    end
    release_job();
  endtask

  task automatic test_reset_mid_job();
    int   lat;
    logic bs;
    bus.x_flat   = XW'(fill_d(5, 16));
    bus.w1_flat  = W1W'(fill_d(-3, 16));
    bus.w2_flat  = W2W'(fill_d(4, 8));
    bus.relu_en  = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (40) step();
    rst = 1'b1;
    step();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || state_dbg !== IDLE ||
        bus.y_flat !== '0 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst: out_valid=%b busy=%b state=%0d in_ready=%b y=%h",
               bus.out_valid, bus.busy, state_dbg, bus.in_ready, bus.y_flat);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_in_ready: in_ready=%b required 1", bus.in_ready);
    end
    run_job(XW'(fill_d(2, 16)), W1W'(fill_d(3, 16)), W2W'(fill_d(-1, 8)), 1'b1, lat, bs);
    n_vec++;
    if (lat !== LAT || bus.y_flat !== fill_y(-96)) begin
      n_err++;
      $display("FAIL midrst_fresh: lat=%0d y=%h, required %0d %h", lat, bus.y_flat, LAT, fill_y(-96));
    end
    release_job();
  endtask

  task automatic test_random();
    logic [XW-1:0]  x;
    logic [W1W-1:0] w1;
    logic [W2W-1:0] w2;
    logic [YW-1:0]  exp_y;
    logic           relu;
    int             lat;
    logic           bs;
    for (int j = 0; j < 200; j++) begin
      for (int k = 0; k < N_NODES * N_IN; k++) x[k*DATA_W +: DATA_W] = 5'($urandom_range(0, 31));
      for (int k = 0; k < N_IN * N_HID; k++) w1[k*DATA_W +: DATA_W] = 5'($urandom_range(0, 31));
      for (int k = 0; k < N_HID * N_OUT; k++) w2[k*DATA_W +: DATA_W] = 5'($urandom_range(0, 31));
      relu = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_y(x, w1, w2, relu));
      run_job(x, w1, w2, relu, lat, bs);
      exp_y = exp_q.pop_front();
      n_vec++;
      if (lat !== LAT || bus.y_flat !== exp_y) begin
        n_err++;
        $display("FAIL random job=%0d: lat=%0d y=%h, required %0d %h", j, lat, bus.y_flat, LAT, exp_y);
      end
      release_job();
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_min();
    test_relu();
    test_backpressure();
    test_reset_mid_job();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gnn_mlp_engine.md
Name: gnn_mlp_engine

Overview:
- Parametrised, time-multiplexed successor to the fixed 4-node / 4-feature / 2-output GNN top.
- Evaluates a two-layer per-node MLP over N_NODES nodes: hidden = W1ᵀx with optional ReLU, then y = W2ᵀhidden.
- Uses a single signed MAC, a valid/ready handshake on both sides, and a synchronous reset.
- Sits between the feature/weight loader and the aggregation stage; it replaces the fully parallel combinational datapath.

Parameters:
N_NODES, 4, number of graph nodes processed per job
N_IN, 4, input features per node
N_HID, 4, hidden neurons
N_OUT, 2, outputs per node
DATA_W, 5, signed width of features and weights
ACC_W, 21, signed output width; elaboration error if ACC_W < 3*DATA_W + clog2(N_IN) + clog2(N_HID)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  job offered
in_ready  out  1  engine can accept a job
x_flat  in  N_NODES*N_IN*DATA_W  signed features; element [n][i] at index (n*N_IN+i)
w1_flat  in  N_IN*N_HID*DATA_W  signed layer-1 weights; element [i][h] at (i*N_HID+h)
w2_flat  in  N_HID*N_OUT*DATA_W  signed layer-2 weights; element [h][o] at (h*N_OUT+o)
relu_en  in  1  apply ReLU to hidden values
out_valid  out  1  results available
out_ready  in  1  consumer takes results
y_flat  out  N_NODES*N_OUT*ACC_W  signed results; element [n][o] at (n*N_OUT+o)
busy  out  1  high in L1 and L2 states

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset response: at the first clk edge with rst high, regardless of state (including mid-job):
  - state=IDLE, out_valid=0, busy=0, y_flat=0, hidden regs=0, all counters=0.
  - The in-flight job is discarded.
  - in_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready: capture x_flat, w1_flat, w2_flat and relu_en into internal regs; clear counters; go to L1. Inputs may change freely after acceptance.
  - L1: one MAC per cycle for node n, hidden h, input i; acc += x[n][i]*w1[i][h]. Loop order: i inner, h outer. On i==N_IN-1, write hid[h] = (relu_en && sum<0) ? 0 : sum, sign-extended to H_W = 2*DATA_W + clog2(N_IN). After the last h, go to L2.
  - L2: one MAC per cycle; acc += hid[h]*w2[h][o]. Loop order: h inner, o outer. On h==N_HID-1, write y[n][o] (sign-extended to ACC_W). After the last o: if n<N_NODES-1, set n++ and go to L1; otherwise go to DONE.
  - DONE: out_valid=1; y_flat is held stable. On out_ready, go to IDLE at the next edge, with out_valid=0.
- Handshake rules:
  - out_ready while out_valid=0 is ignored.
  - in_valid outside IDLE is ignored, with no capture.
  - There is one mandatory IDLE cycle between jobs; a DONE→L1 shortcut is forbidden.
  - y_flat retains the last results until the next job overwrites each entry during computation. Entries are overwritten progressively.
- Latency: acceptance at edge 0 → out_valid high after edge LAT = N_NODES*(N_IN*N_HID + N_HID*N_OUT). Default LAT = 96. LAT is constant and data-independent.
- Arithmetic:
  - All operations are two's-complement signed; products are full width.
  - The accumulator is cleared at the first term of each sum, with no carry between sums.
  - No saturation; widths are exact, so overflow is impossible given the ACC_W check.
  - The -16 × -16 case must be exact.
- Hidden storage: N_HID regs, reused for every node.

Decomposition:
- gnn_pkg:
  - state enum (IDLE, L1, L2, DONE)
  - functions hid_w() and acc_w_min() for the width rules
  - index helper functions for the flat-array layout
- Sub-module gnn_mac:
  - signed multiply-accumulate with a clr_first input and parametrised operand/accumulator widths
  - instantiated once, shared by L1 and L2 through operand muxes

Test Plan:
- Reset mid-L2 (assert rst at cycle 40 of a job) → next edge: out_valid=0, y_flat=0, busy=0; in_ready=1 the cycle rst drops; a fresh job then completes correctly.
- Maximum: all x, w1, w2 = +15, relu_en=1 → every y = 54000, out_valid exactly 96 edges after accept.
- Minimum: all x, w1, w2 = -16, relu_en=0 → hidden = 1024, every y = -65536; the result is the same with relu_en=1.
- ReLU mode: x=+1, w1=-1, w2=+1 → relu_en=1 gives y=0; relu_en=0 gives y=-16 for all nodes and outputs.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → y_flat stable, in_ready=0, in_valid pulses ignored; out_ready=1 → IDLE next edge, next job accepted one cycle later.
- Mixed signs: 4-node vectors with negative weights, random relu_en, 200 random jobs → compared against the reference model; inputs changed right after accept must not affect results.
